// File: rtl/fsm_vedacao_if.sv
// Handshake between the master sequencer and the cork sealing station.
// The master raises the command; the station answers with done and alarm.
interface fsm_vedacao_if;
   logic cmd_vedar;
   logic vedacao_concluida;
   logic alarme_rolha;

   modport master (
      output cmd_vedar,
      input  vedacao_concluida,
      input  alarme_rolha
   );

   modport slave (
      input  cmd_vedar,
      output vedacao_concluida,
      output alarme_rolha
   );
endinterface

// File: rtl/fsm_vedacao.sv
// Cork sealing station slave FSM with stock counter and empty alarm.
// Define AVISO_ESTOQUE_EN to add the registered low-stock warning aviso_baixo.
module fsm_vedacao #(
   parameter int ESTOQUE_INICIAL = 20,
   parameter int ESTOQUE_MAX     = 99,
   parameter int INCREMENTO      = 15,
   parameter int TEMPO_VEDACAO   = 50,
   parameter int LIMIAR_AVISO    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       botao_repor,
   fsm_vedacao_if.slave bus,
   output logic       vedando,
   output logic [6:0] estoque_rolhas
`ifdef AVISO_ESTOQUE_EN
   ,
   output logic       aviso_baixo
`endif
);

   localparam int TW = (TEMPO_VEDACAO > 1) ? $clog2(TEMPO_VEDACAO) : 1;
   localparam logic [TW-1:0] T_FIM = TW'(TEMPO_VEDACAO - 1);
   localparam logic [6:0] E_INI = 7'(ESTOQUE_INICIAL);
   localparam logic [6:0] E_MAX = 7'(ESTOQUE_MAX);
   localparam logic [7:0] E_MAX8 = 8'(ESTOQUE_MAX);
   localparam logic [7:0] INC8 = 8'(INCREMENTO);

   typedef enum logic [2:0] {
      IDLE,
      VEDANDO,
      CONCLUI,
      LIBERA,
      SEM_ROLHA
   } estado_t;

   estado_t       state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [6:0]    estoque_q, estoque_d;
   logic          vedando_q, vedando_d;
   logic          concl_q, concl_d;
   logic          alarme_q, alarme_d;
   logic [6:0]    base;
   logic [7:0]    soma;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_vedar) begin
               if (estoque_q == 7'd0) begin
                  state_d = SEM_ROLHA;
               end else begin
                  state_d = VEDANDO;
                  timer_d = '0;
               end
            end
         end
         VEDANDO: begin
            if (timer_q == T_FIM) state_d = CONCLUI;
            else                  timer_d = timer_q + 1'b1;
         end
         CONCLUI: state_d = LIBERA;
         LIBERA: begin
            if (!bus.cmd_vedar) state_d = IDLE;
         end
         SEM_ROLHA: begin
            if (!bus.cmd_vedar) begin
               state_d = IDLE;
            end else if (estoque_q != 7'd0) begin
               state_d = VEDANDO;
               timer_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Decrement and refill may land in the same cycle
      base = estoque_q - {6'd0, (state_q == CONCLUI)};
      soma = {1'b0, base} + INC8;
      estoque_d = base;
      if (botao_repor) begin
         estoque_d = (soma > E_MAX8) ? E_MAX : soma[6:0];
      end

      vedando_d = (state_d == VEDANDO);
      concl_d   = (state_d == CONCLUI);
      alarme_d  = (estoque_q == 7'd0);
   end

`ifdef AVISO_ESTOQUE_EN
   localparam logic [6:0] LIM = 7'(LIMIAR_AVISO);
   logic aviso_q;
   logic aviso_d;

   always_comb begin
      aviso_d = (estoque_q != 7'd0) && (estoque_q <= LIM);
   end

   always_ff @(posedge clk) begin
      if (reset) aviso_q <= (E_INI != 7'd0) && (E_INI <= LIM);
      else       aviso_q <= aviso_d;
   end

   assign aviso_baixo = aviso_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         estoque_q <= E_INI;
         vedando_q <= 1'b0;
         concl_q   <= 1'b0;
         alarme_q  <= (E_INI == 7'd0);
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         estoque_q <= estoque_d;
         vedando_q <= vedando_d;
         concl_q   <= concl_d;
         alarme_q  <= alarme_d;
      end
   end

   assign vedando               = vedando_q;
   assign estoque_rolhas        = estoque_q;
   assign bus.vedacao_concluida = concl_q;
   assign bus.alarme_rolha      = alarme_q;

endmodule

// File: tb/tb_fsm_vedacao.sv
// Directed bench for fsm_vedacao: two instances, stock 20 and stock 1,
// both with a 4-cycle sealing time.
module tb_fsm_vedacao;

   logic clk = 1'b0;
   logic rst[2];
   logic cmd[2];
   logic repor[2];
   logic done[2];
   logic alarm[2];
   logic ved[2];
   logic [6:0] stock[2];
`ifdef AVISO_ESTOQUE_EN
   logic aviso[2];
`endif

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   fsm_vedacao_if if_a ();
   fsm_vedacao_if if_b ();

   assign if_a.cmd_vedar = cmd[0];
   assign if_b.cmd_vedar = cmd[1];
   assign done[0]  = if_a.vedacao_concluida;
   assign done[1]  = if_b.vedacao_concluida;
   assign alarm[0] = if_a.alarme_rolha;
   assign alarm[1] = if_b.alarme_rolha;

   fsm_vedacao #(
      .ESTOQUE_INICIAL(20),
      .TEMPO_VEDACAO(4)
   ) dut_a (
      .clk(clk),
      .reset(rst[0]),
      .botao_repor(repor[0]),
      .bus(if_a),
      .vedando(ved[0]),
      .estoque_rolhas(stock[0])
`ifdef AVISO_ESTOQUE_EN
      ,
      .aviso_baixo(aviso[0])
`endif
   );

   fsm_vedacao #(
      .ESTOQUE_INICIAL(1),
      .TEMPO_VEDACAO(4)
   ) dut_b (
      .clk(clk),
      .reset(rst[1]),
      .botao_repor(repor[1]),
      .bus(if_b),
      .vedando(ved[1]),
      .estoque_rolhas(stock[1])
`ifdef AVISO_ESTOQUE_EN
      ,
      .aviso_baixo(aviso[1])
`endif
   );

   // full seal with cmd held until done, then released; returns pulse count
   task automatic seal(input int d, output int pulses);
      pulses = 0;
      @(negedge clk);
      cmd[d] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done[d] === 1'b1) begin
            pulses++;
            break;
         end
      end
      @(negedge clk);
      cmd[d] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic refill(input int d);
      @(negedge clk);
      repor[d] = 1'b1;
      @(negedge clk);
      repor[d] = 1'b0;
   endtask

   task automatic test_reset;
      rst[0] = 1'b1; rst[1] = 1'b1;
      cmd[0] = 1'b0; cmd[1] = 1'b0;
      repor[0] = 1'b0; repor[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (stock[0] !== 7'd20 || alarm[0] !== 1'b0 ||
          ved[0] !== 1'b0 || done[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: stock=%0d alarm=%b ved=%b done=%b want 20 0 0 0",
                  stock[0], alarm[0], ved[0], done[0]);
      end
      checks++;
      if (stock[1] !== 7'd1 || alarm[1] !== 1'b0 ||
          ved[1] !== 1'b0 || done[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: stock=%0d alarm=%b ved=%b done=%b want 1 0 0 0",
                  stock[1], alarm[1], ved[1], done[1]);
      end
`ifdef AVISO_ESTOQUE_EN
      checks++;
      if (aviso[0] !== 1'b0 || aviso[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_aviso: a=%b b=%b want 0 1", aviso[0], aviso[1]);
      end
`endif
   endtask

   task automatic test_seal_basic;
      int nved;
      int npulse;
      int overlap;
      nved = 0; npulse = 0; overlap = 0;
      cmd[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (ved[0] === 1'b1) nved++;
         if (done[0] === 1'b1) npulse++;
         if (done[0] === 1'b1 && ved[0] === 1'b1) overlap++;
      end
      checks++;
      if (nved != 4) begin
         errors++;
         $display("FAIL seal_ved_cycles: got %0d want 4", nved);
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL seal_pulses: got %0d want 1", npulse);
      end
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL seal_overlap: got %0d want 0", overlap);
      end
      checks++;
      if (stock[0] !== 7'd19) begin
         errors++;
         $display("FAIL seal_stock: got %0d want 19", stock[0]);
      end
      cmd[0] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_last_cork;
      int ok;
      int p;
      cmd[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done[1] === 1'b1) break;
      end
      checks++;
      if (done[1] !== 1'b1 || stock[1] !== 7'd1 || alarm[1] !== 1'b0) begin
         errors++;
         $display("FAIL last_pulse: done=%b stock=%0d alarm=%b want 1 1 0",
                  done[1], stock[1], alarm[1]);
      end
      @(negedge clk);
      checks++;
      if (stock[1] !== 7'd0 || alarm[1] !== 1'b0) begin
         errors++;
         $display("FAIL last_stock0: stock=%0d alarm=%b want 0 0",
                  stock[1], alarm[1]);
      end
      @(negedge clk);
      checks++;
      if (alarm[1] !== 1'b1) begin
         errors++;
         $display("FAIL last_alarm: got %b want 1", alarm[1]);
      end
      cmd[1] = 1'b0;
      repeat (2) @(negedge clk);
      cmd[1] = 1'b1;
      ok = 1;
      repeat (4) begin
         @(negedge clk);
         if (ved[1] !== 1'b0 || done[1] !== 1'b0) ok = 0;
      end
      checks++;
      if (ok != 1) begin
         errors++;
         $display("FAIL sem_rolha: ved/done seen with empty stock, want none");
      end
      refill(1);
      checks++;
      if (stock[1] !== 7'd15 || alarm[1] !== 1'b1) begin
         errors++;
         $display("FAIL refill_stock: stock=%0d alarm=%b want 15 1",
                  stock[1], alarm[1]);
      end
      @(negedge clk);
      checks++;
      if (ved[1] !== 1'b1 || alarm[1] !== 1'b0) begin
         errors++;
         $display("FAIL resume: ved=%b alarm=%b want 1 0", ved[1], alarm[1]);
      end
      p = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done[1] === 1'b1) begin
            p = 1;
            break;
         end
      end
      @(negedge clk);
      checks++;
      if (p != 1 || stock[1] !== 7'd14) begin
         errors++;
         $display("FAIL resume_done: pulse=%0d stock=%0d want 1 14", p, stock[1]);
      end
      cmd[1] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation;
      int p;
      int bad;
      repeat (5) refill(0);
      checks++;
      if (stock[0] !== 7'd94) begin
         errors++;
         $display("FAIL refill_sum: got %0d want 94", stock[0]);
      end
      bad = 0;
      repeat (4) begin
         seal(0, p);
         if (p != 1) bad++;
      end
      checks++;
      if (bad != 0 || stock[0] !== 7'd90) begin
         errors++;
         $display("FAIL seal_to_90: badseals=%0d stock=%0d want 0 90", bad, stock[0]);
      end
      refill(0);
      checks++;
      if (stock[0] !== 7'd99) begin
         errors++;
         $display("FAIL sat_first: got %0d want 99", stock[0]);
      end
      refill(0);
      checks++;
      if (stock[0] !== 7'd99) begin
         errors++;
         $display("FAIL sat_second: got %0d want 99", stock[0]);
      end
   endtask

   task automatic test_refill_in_conclui;
      int p;
      int bad;
      bad = 0;
      repeat (9) begin
         seal(1, p);
         if (p != 1) bad++;
      end
      checks++;
      if (bad != 0 || stock[1] !== 7'd5) begin
         errors++;
         $display("FAIL seal_to_5: badseals=%0d stock=%0d want 0 5", bad, stock[1]);
      end
      cmd[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done[1] === 1'b1) break;
      end
      repor[1] = 1'b1;
      @(negedge clk);
      repor[1] = 1'b0;
      checks++;
      if (stock[1] !== 7'd19) begin
         errors++;
         $display("FAIL conclui_refill: got %0d want 19", stock[1]);
      end
      cmd[1] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_seal;
      int npulse;
      cmd[0] = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ved[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_ved: got %b want 1", ved[0]);
      end
      rst[0] = 1'b1;
      cmd[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (ved[0] !== 1'b0 || stock[0] !== 7'd20 || done[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: ved=%b stock=%0d done=%b want 0 20 0",
                  ved[0], stock[0], done[0]);
      end
      rst[0] = 1'b0;
      npulse = 0;
      repeat (10) begin
         @(negedge clk);
         if (done[0] === 1'b1) npulse++;
      end
      checks++;
      if (npulse != 0 || stock[0] !== 7'd20) begin
         errors++;
         $display("FAIL mid_no_pulse: pulses=%0d stock=%0d want 0 20",
                  npulse, stock[0]);
      end
   endtask

   initial begin
      test_reset();
      test_seal_basic();
      test_last_cork();
      test_saturation();
      test_refill_in_conclui();
      test_reset_mid_seal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
